// File: rtl/rvskid_width17_if.sv
// Valid/ready channel bundle for the 17-bit skid buffer: producer side (in_*)
// and consumer side (out_*).
interface rvskid_width17_if #(
  parameter int WIDTH = 17
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1.
  // The buffer's ready and valid depend only on its own registered state.
  // Once valid is raised, data is held until that beat transfers.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rvskid_width17.sv
// Two-entry elastic skid buffer (main + skid register) with registered
// handshakes and a saturating stall counter.
module rvskid_width17 #(
  parameter int WIDTH   = 17,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  rvskid_width17_if.slave    bus,
  output logic [1:0]         count,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             push;
  logic             pop;
  logic             stall;

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = main_q;

  // The occupancy output is the FSM state itself, so it doubles as state debug.
  assign count = state;

  assign push  = bus.in_valid & bus.in_ready;
  assign pop   = bus.out_valid & bus.out_ready;
  assign stall = bus.out_valid & ~bus.out_ready;

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = bus.in_data;
          end else if (push) begin
            state_d = FULL;
            skid_d  = bus.in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // The skid entry is always the younger one, so it moves into main.
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rvskid_width17.sv
// Randomized and directed bench for rvskid_width17, scored against a queue
// model of a two-deep FIFO with a saturating stall count.
module tb_rvskid_width17;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  count;
  logic [7:0]  stall_cnt;

  rvskid_width17_if #(.WIDTH(17)) bus ();

  rvskid_width17 #(.WIDTH(17), .STALL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [16:0] exp_q[$];
  int          stall_m;
  bit          known;
  bit          fresh_reset;
  int          n_vec;
  int          n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    if (!known) return;
    sz = exp_q.size();
    check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, sz != 0});
    check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, sz < 2});
    check_eq("count", {30'd0, count}, sz);
    check_eq("stall_cnt", {24'd0, stall_cnt}, stall_m);
    if (sz != 0)
      check_eq("out_data", {15'd0, bus.out_data}, {15'd0, exp_q[0]});
    else if (fresh_reset)
      check_eq("out_data_rst", {15'd0, bus.out_data}, 32'd0);
  endtask

  // driver: called at a falling edge; checks, drives one cycle, updates the model
  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [16:0] d, input logic ordy);
    int sz;
    check_outputs();
    rst           = r;
    flush         = f;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    if (r) begin
      exp_q.delete();
      stall_m     = 0;
      known       = 1'b1;
      fresh_reset = 1'b1;
    end else if (known) begin
      sz = exp_q.size();
      if (sz > 0 && !ordy && stall_m < 255) stall_m++;
      if (f) begin
        exp_q.delete();
      end else begin
        if (sz > 0 && ordy) void'(exp_q.pop_front());
        if (iv && sz < 2) begin
          exp_q.push_back(d);
          fresh_reset = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    known = 1'b0;
    fresh_reset = 1'b0;
    stall_m = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // reset with a producer hammering input
    cycle(1'b1, 1'b0, 1'b1, 17'h1FFFF, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 17'h1FFFF, 1'b0);
    check_eq("rst_out_data", {15'd0, bus.out_data}, 32'd0);
    check_eq("rst_stall", {24'd0, stall_cnt}, 32'd0);

    // streaming at full rate
    for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b0, 1'b1, 17'(i), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 17'h0, 1'b1);

    // skid and backpressure
    cycle(1'b0, 1'b0, 1'b1, 17'h0AAAA, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 17'h15555, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 17'h00BAD, 1'b0);
    check_eq("skid_full_count", {30'd0, count}, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 17'h0, 1'b1);

    // flush while full, with a push that must be dropped
    cycle(1'b0, 1'b0, 1'b1, 17'h00111, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 17'h00222, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 17'h12345, 1'b1);
    check_eq("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 17'h00777, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 17'h0, 1'b1);

    // stall counter saturation, then reset clears it
    cycle(1'b0, 1'b0, 1'b1, 17'h1ABCD, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b0, 17'h0, 1'b0);
    check_eq("stall_sat", {24'd0, stall_cnt}, 32'd255);
    cycle(1'b1, 1'b0, 1'b0, 17'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 17'h0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, f, iv, ordy;
      logic [16:0] d;
      r    = ($urandom_range(0, 299) == 0);
      ordy = ($urandom_range(0, 99) < 60);
      f    = ordy && ($urandom_range(0, 59) == 0);
      iv   = ($urandom_range(0, 99) < 65);
      d    = 17'($urandom);
      cycle(r, f, iv, d, ordy);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
